// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : Bounded LIFO of return addresses for the single-cycle core.
//               JSB pushes PC+1, RET pops it back to the PC-source mux.
//               Registered storage, combinational top-of-stack read and
//               sticky overflow/underflow error flags.
// Ports       : clk        - single clock, rising edge
//               rst        - asynchronous active-high reset
//               push_stack - push push_data this cycle
//               pop_stack  - pop the top entry this cycle
//               push_data  - return address to push
//               top        - current top entry, 0 when empty
//               count      - number of valid entries
//               empty      - count == 0
//               full       - count == DEPTH
//               overflow   - sticky: push attempted while full
//               underflow  - sticky: pop attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_stack,
  input  logic                     pop_stack,
  input  logic [ADDR_WIDTH-1:0]    push_data,
  output logic [ADDR_WIDTH-1:0]    top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_SP_W  = c_IDX_W + 1;

  localparam logic [c_SP_W-1:0]  c_SP_DEPTH = c_SP_W'(DEPTH);
  localparam logic [c_SP_W-1:0]  c_SP_ONE   = c_SP_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [c_SP_W-1:0]     r_sp;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic [c_IDX_W-1:0]    w_top_idx;
  logic                  w_push_only;
  logic                  w_pop_only;
  logic                  w_both;
  logic                  w_wr_en;
  logic [c_IDX_W-1:0]    w_wr_idx;
  logic                  w_sp_inc;
  logic                  w_sp_dec;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == c_SP_DEPTH);

  // Index of the top entry. When the stack is full sp's low bits wrap to
  // zero, so the subtraction wraps to DEPTH-1, which is exactly the top slot.
  assign w_top_idx = r_sp[c_IDX_W-1:0] - c_IDX_ONE;

  assign w_push_only = push_stack & ~pop_stack;
  assign w_pop_only  = pop_stack & ~push_stack;
  assign w_both      = push_stack & pop_stack;

  // Push+pop replaces the top in place (legal when full). On an empty stack
  // it degenerates to a plain push into slot 0, which is also sp's low bits.
  assign w_wr_en  = (w_push_only & ~w_full) | w_both;
  assign w_wr_idx = (w_both & ~w_empty) ? w_top_idx : r_sp[c_IDX_W-1:0];

  assign w_sp_inc = (w_push_only & ~w_full) | (w_both & w_empty);
  assign w_sp_dec = w_pop_only & ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_sp_inc) begin
        r_sp <= r_sp + c_SP_ONE;
      end else if (w_sp_dec) begin
        r_sp <= r_sp - c_SP_ONE;
      end
      if (w_push_only & w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_only & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Storage is never cleared: entries above sp are unobservable, so reset
  // only needs to collapse the pointer.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  assign top       = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: doc/return_stack.md
# return_stack

Return-address stack for the single-cycle processor. It holds the return PCs pushed by `JSB` and supplies them to the PC-source mux on `RET`. It sits between the controller's `push_stack`/`pop_stack` strobes and the PC-select logic (`sel_PCSrc_stack` path). It is a bounded LIFO with registered storage, a combinational top-of-stack read, and sticky overflow/underflow error flags.

## Interface
- `DEPTH`, 8: number of entries; must be a power of two, at least 2.
- `ADDR_WIDTH`, 12: width of a stored return address (PC width).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `push_stack` input 1: push `push_data` this cycle (controller `JSB`).
- `pop_stack` input 1: pop the top entry this cycle (controller `RET`).
- `push_data` input `ADDR_WIDTH`: return address to push (PC+1 from the PC adder).
- `top` output `ADDR_WIDTH`: current top entry (combinational from stored state); 0 when empty.
- `count` output `$clog2(DEPTH)+1`: number of valid entries.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == DEPTH`.
- `overflow` output 1: sticky; push attempted while full.
- `underflow` output 1: sticky; pop attempted while empty.

## Operation
- Storage: `DEPTH` registers `mem[0..DEPTH-1]`, plus a stack pointer `sp` equal to `count`. Valid entries are `mem[0..sp-1]`; `top = mem[sp-1]`.
- Behaviour on each rising edge, by `{push_stack, pop_stack}`:
  - `00`: no change.
  - `10`, not full: `mem[sp] <= push_data`; `sp <= sp+1`.
  - `10`, full: storage and `sp` unchanged; `overflow <= 1`.
  - `01`, not empty: `sp <= sp-1`. Storage is not cleared.
  - `01`, empty: no change; `underflow <= 1`.
  - `11`, not empty: replace the top, `mem[sp-1] <= push_data`; `sp` unchanged. This is legal even when full and does not set `overflow`.
  - `11`, empty: acts as a push, `mem[0] <= push_data`; `sp <= 1`. `underflow` is not set.
- `overflow` and `underflow` clear only on `rst`.
- No internal pipeline or state machine beyond `sp` and the flags; the block is always ready.

## Timing
- Reset (asynchronous, takes effect immediately on `rst` high, independent of `clk`):
  - `sp = 0`, so `count = 0`, `empty = 1`, `full = 0`, `top = 0`.
  - `overflow = 0`, `underflow = 0`.
  - `mem` contents need not be cleared; they are unobservable while empty.
- Pop: `top` presents the return address combinationally in the same cycle `pop_stack` is asserted, so the PC mux loads it at that edge. `sp` decrements at the same edge.
- Push: `push_data` is captured at the edge. The new value appears on `top` in the following cycle (zero-cycle write-to-read latency after the edge).
- `count`, `empty`, `full` and the flags are registered-derived and change only at edges or on reset.
- Reset asserted mid-operation (e.g. coincident with a push) wins: the push is discarded and the stack is empty after reset.
- `push_data` X while `push_stack = 0` must not affect state.

## Test plan
- Reset, then idle 3 cycles: `empty = 1`, `count = 0`, `top = 0x000`, both flags 0.
- Push `0x010`, `0x020`, `0x030` on consecutive cycles: `count = 3`, `top = 0x030`. Pop three times: `top` reads `0x030`, `0x020`, `0x010` in the pop cycles. Afterwards `empty = 1`, `underflow = 0`.
- Push 8 values `0x100..0x107`: `full = 1`. A 9th push of `0x1FF` sets `overflow = 1`, `top` stays `0x107`, `count` stays 8. Eight pops return `0x107..0x100` in order.
- Pop while empty: `underflow = 1`, `count` stays 0. A following push of `0x055` gives `top = 0x055`, and `underflow` remains 1 until reset.
- Simultaneous push+pop:
  - With stack `[0x011, 0x022]`, push+pop with `0x0AA`: stack becomes `[0x011, 0x0AA]`, `count = 2`.
  - On an empty stack, push+pop with `0x0BB`: `count = 1`, `top = 0x0BB`, no flags set.
- Push `0x0CC` and `0x0DD`, then assert `rst` asynchronously between clock edges: outputs return immediately to the reset values. A push of `0x0EE` after reset release gives `count = 1`, `top = 0x0EE`.
